// File: rtl/handshake_pkg.sv
// handshake_pkg: shared constants and helpers for the handshake_* blocks.
//   HS_MAX_SLOTS : largest supported FIFO depth
//   hs_cnt_w(n)  : width of an occupancy counter that must hold 0..n
//   hs_ptr_next  : circular pointer increment with wrap at n-1 (n need not be 2^k)
package handshake_pkg;

  localparam int HS_MAX_SLOTS = 256;

  function automatic int hs_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned hs_ptr_next(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// handshake_fifo_mem: NUM_SLOTS x DATA_WIDTH register array, reset to zero.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   we/waddr/wdata  synchronous write port
//   raddr/rdata     asynchronous read port
module handshake_fifo_mem
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4,
  parameter int AW         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo_buffer.sv
// handshake_fifo_buffer: elastic in-order FIFO on one valid/ready channel.
// ins_ready is registered, so there is no combinational ready path back to
// the producer. Default build is opaque with one cycle of latency.
// Optional feature macro: HANDSHAKE_FIFO_BYPASS_EN -- when empty, an incoming
// token is presented combinationally on outs (zero latency).
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ins, ins_valid, ins_ready     producer side
//   outs, outs_valid, outs_ready  consumer side
module handshake_fifo_buffer
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = hs_cnt_w(NUM_SLOTS);
  localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);

  if (NUM_SLOTS < 2 || NUM_SLOTS > HS_MAX_SLOTS) begin : g_bad_depth
    $error("handshake_fifo_buffer: NUM_SLOTS out of range");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] mem_rdata, last_q;
  logic                  push, pop, take, mem_we, bypass;
  logic                  stored;

  handshake_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_SLOTS (NUM_SLOTS),
    .AW        (AW)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(wr_ptr),
    .wdata(ins),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  assign stored = (count != '0);

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  // Gated by rst so nothing is presented while the block is held in reset.
  assign bypass = rst && ins_valid && !stored;

  always_comb begin
    outs_valid = stored || bypass;
    outs       = last_q;
    if (stored)      outs = mem_rdata;
    else if (bypass) outs = ins;
  end
`else
  assign bypass = 1'b0;

  // last_q keeps outs steady (and non-X) while the buffer is empty.
  always_comb begin
    outs_valid = stored;
    outs       = stored ? mem_rdata : last_q;
  end
`endif

  assign ins_ready = ready_q;
  assign push      = ins_valid && ready_q;
  assign pop       = outs_valid && outs_ready;
  // take: the popped token came out of storage (not straight through bypass)
  assign take      = pop && stored;
  assign mem_we    = push && !(bypass && pop);

  always_comb begin
    count_next = count;
    if (mem_we && !take)      count_next = count + CW'(1);
    else if (take && !mem_we) count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
      last_q  <= '0;
    end else begin
      count <= count_next;
      // Looking at count_next means a pop while full only reopens the
      // input on the following cycle, never in the same one.
      ready_q <= (count_next != FULL);
      if (mem_we) wr_ptr <= AW'(hs_ptr_next(32'(wr_ptr), NUM_SLOTS));
      if (take)   rd_ptr <= AW'(hs_ptr_next(32'(rd_ptr), NUM_SLOTS));
      if (pop)    last_q <= outs;
    end
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
module tb_handshake_fifo_buffer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] ins = '0;
  logic          ins_valid = 1'b0;
  logic          outs_ready = 1'b0;

  logic [1:0]    rdy, vld;
  logic [DW-1:0] dat [2];

  always #5 clk = ~clk;

  handshake_fifo_buffer #(.DATA_WIDTH(DW), .NUM_SLOTS(4)) u_dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(rdy[0]),
    .outs(dat[0]), .outs_valid(vld[0]), .outs_ready(outs_ready)
  );

  handshake_fifo_buffer #(.DATA_WIDTH(DW), .NUM_SLOTS(3)) u_dut3 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(rdy[1]),
    .outs(dat[1]), .outs_valid(vld[1]), .outs_ready(outs_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one token queue per instance.
  logic [DW-1:0] mq [2][$];
  logic          mready [2];
  logic [DW-1:0] mlast [2];
  int            slots [2] = '{4, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_valid(input int k);
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    return rst && (mq[k].size() != 0 || ins_valid);
`else
    return mq[k].size() != 0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input int k);
    if (mq[k].size() != 0) return mq[k][0];
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    if (rst && ins_valid) return ins;
`endif
    return mlast[k];
  endfunction

  function automatic int dut_count(input int k);
    return (k == 0) ? int'(u_dut4.count) : int'(u_dut3.count);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mready[k] = 1'b1;
      mlast[k]  = '0;
    end
  endtask

  task automatic model_edge();
    logic v, push, pop;
    logic [DW-1:0] h;
    if (!rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        v    = exp_valid(k);
        h    = exp_data(k);
        push = ins_valid && mready[k];
        pop  = v && outs_ready;
        if (pop) mlast[k] = h;
        if (!(mq[k].size() == 0 && push && pop)) begin
          if (pop)  void'(mq[k].pop_front());
          if (push) mq[k].push_back(ins);
        end
        mready[k] = (mq[k].size() != slots[k]);
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/d%0d/ins_ready", ph, slots[k]), 32'(rdy[k]), 32'(mready[k]));
      chk($sformatf("%s/d%0d/outs_valid", ph, slots[k]), 32'(vld[k]), 32'(exp_valid(k)));
      chk($sformatf("%s/d%0d/outs", ph, slots[k]), 32'(dat[k]), 32'(exp_data(k)));
      chk($sformatf("%s/d%0d/count", ph, slots[k]), 32'(dut_count(k)), 32'(mq[k].size()));
    end
  endtask

  // One cycle: check between edges, then advance the model on the edge.
  task automatic step(input string ph);
    @(negedge clk);
    check_all(ph);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  logic [DW-1:0] seq [$];
  int            t;
  logic          acc;
  int            pv, pr;

  initial begin
    model_reset();

    // Reset held with a token offered.
    rst = 1'b0; ins_valid = 1'b1; ins = 16'h00aa;
    repeat (3) step("reset");
    rst = 1'b1; ins_valid = 1'b0;
    repeat (2) step("idle");

    // Constant stream.
    ins = 16'd3; ins_valid = 1'b1; outs_ready = 1'b1;
    repeat (8) step("const");

    // Drain, then fill and drain with tokens 1..6.
    ins_valid = 1'b0;
    repeat (6) step("drain0");
    outs_ready = 1'b0; t = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 8) outs_ready = 1'b1;
      ins_valid = (t <= 6);
      ins = DW'(t);
      acc = ins_valid && mready[0];
      step("fill");
      if (acc) t++;
    end
    ins_valid = 1'b0;
    repeat (6) step("drain1");

    // Wrap-around on the 3-deep instance, consumer toggling every cycle.
    seq.delete(); t = 0;
    for (int c = 0; c < 40; c++) begin
      outs_ready = c[0];
      ins_valid  = (t <= 9);
      ins = DW'(t);
      acc = ins_valid && mready[1];
      @(negedge clk);
      if (vld[1] && outs_ready) seq.push_back(dat[1]);
      check_all("wrap");
      @(posedge clk);
      model_edge();
      #1;
      if (acc) t++;
    end
    chk("wrap/seq_len", 32'(seq.size()), 32'd10);
    for (int i = 0; i < seq.size() && i < 10; i++)
      chk($sformatf("wrap/seq%0d", i), 32'(seq[i]), 32'(i));

    // Simultaneous push and pop with two tokens stored.
    ins_valid = 1'b0; outs_ready = 1'b1;
    repeat (6) step("drain2");
    outs_ready = 1'b0; ins_valid = 1'b1;
    ins = 16'h0020; step("pp_fill");
    ins = 16'h0021; step("pp_fill");
    chk("pp/count_before", 32'(dut_count(0)), 32'd2);
    ins = 16'h0022; outs_ready = 1'b1;
    step("pp");
    ins_valid = 1'b0; outs_ready = 1'b0;
    @(negedge clk);
    chk("pp/count_after", 32'(dut_count(0)), 32'd2);
    chk("pp/head", 32'(dat[0]), 32'h21);
    @(posedge clk); model_edge(); #1;

    // Randomized traffic with changing densities.
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        pv = $urandom_range(10, 100);
        pr = $urandom_range(10, 100);
      end
      ins_valid  = ($urandom_range(1, 100) <= pv);
      outs_ready = ($urandom_range(1, 100) <= pr);
      ins = DW'($urandom);
      step("rand");
    end

    // Asynchronous reset between edges with three tokens stored.
    ins_valid = 1'b0; outs_ready = 1'b1;
    repeat (6) step("drain3");
    outs_ready = 1'b0; ins_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins = DW'(16'h0100 + i);
      step("arst_fill");
    end
    ins_valid = 1'b0;
    @(negedge clk);
    chk("arst/count3", 32'(dut_count(0)), 32'd3);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst/d%0d/valid_now", slots[k]), 32'(vld[k]), 32'd0);
      chk($sformatf("arst/d%0d/ready_now", slots[k]), 32'(rdy[k]), 32'd1);
      chk($sformatf("arst/d%0d/outs_now", slots[k]), 32'(dat[k]), 32'd0);
      chk($sformatf("arst/d%0d/count_now", slots[k]), 32'(dut_count(k)), 32'd0);
    end
    model_reset();
    @(posedge clk); #1;
    step("arst_hold");
    rst = 1'b1; outs_ready = 1'b1;
    repeat (4) step("arst_post");
    ins = 16'h0bee; ins_valid = 1'b1;
    repeat (3) step("arst_resume");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
